eucl_sequencer: RTL

Program sequencer for the `eucl` core. It holds a 16-entry × 21-bit program store and presents the instruction word `pm_cont` at program address `p_c` each clock. It feeds the core's `p_c_out` back as the next address. It detects completion and captures the result from `dataout`. It sits between the host (program loader / run control) and `eucl`, replacing the manual `p_c = p_c_out` feedback loop.

---
 rtl/eucl_pkg.sv | 22 ++
 rtl/eucl_prog_mem.sv | 25 ++
 rtl/eucl_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/eucl_pkg.sv
// Shared constants, state encoding and helpers for the eucl program sequencer.
package eucl_pkg;

  localparam int PC_W_DEF    = 4;
  localparam int INSTR_W_DEF = 21;
  localparam int DATA_W_DEF  = 8;
  localparam int MAX_CYC_DEF = 255;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/eucl_prog_mem.sv
// Program store: 2^PC_W x INSTR_W register file, one synchronous write port and
// one combinational read port. Contents are deliberately not reset.
module eucl_prog_mem #(
  parameter int PC_W    = 4,
  parameter int INSTR_W = 21
) (
  input  logic               clock,
  input  logic               we,
  input  logic [PC_W-1:0]    waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [PC_W-1:0]    raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [2**PC_W];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/eucl_sequencer.sv
// Program sequencer for the eucl core: owns the program store, closes the p_c_out -> p_c
// loop, detects branch-to-self halts, enforces a cycle limit and captures the result.
module eucl_sequencer
  import eucl_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MAX_CYC = MAX_CYC_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_en,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               abort,
  input  logic [PC_W-1:0]    p_c_out,
  input  logic [DATA_W-1:0]  dataout,
  output logic [PC_W-1:0]    p_c,
  output logic [INSTR_W-1:0] pm_cont,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [DATA_W-1:0]  result,
  output logic [CNT_W-1:0]   cyc_cnt
);

  seq_state_t         state, state_nxt;
  logic [PC_W-1:0]    p_c_nxt;
  logic [INSTR_W-1:0] pm_cont_nxt;
  logic               timeout_nxt;
  logic [DATA_W-1:0]  result_nxt;
  logic [CNT_W-1:0]   cyc_cnt_nxt;
  logic [CNT_W-1:0]   cyc_inc;
  logic               ready;
  logic               mem_we;
  logic               halt;
  logic               limit;
  logic [PC_W-1:0]    rd_addr;
  logic [INSTR_W-1:0] rd_data;

  assign ready   = (state == IDLE) || (state == DONE);
  assign mem_we  = load_en && ready;
  assign halt    = (p_c_out == p_c);
  assign cyc_inc = sat_inc(cyc_cnt);
  assign limit   = (int'(cyc_inc) >= MAX_CYC);
  assign busy    = (state == FETCH) || (state == EXEC);
  assign done    = (state == DONE);

  // FETCH reads the address already held in p_c; EXEC prefetches the core's next address.
  assign rd_addr = (state == EXEC) ? p_c_out : p_c;

  eucl_prog_mem #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_prog_mem (
    .clock (clock),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_nxt   = state;
    p_c_nxt     = p_c;
    pm_cont_nxt = pm_cont;
    timeout_nxt = timeout;
    result_nxt  = result;
    cyc_cnt_nxt = cyc_cnt;
    case (state)
      IDLE, DONE: begin
        if ((state == DONE) && abort) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt   = FETCH;
          p_c_nxt     = '0;
          timeout_nxt = 1'b0;
          cyc_cnt_nxt = '0;
        end
      end
      FETCH: begin
        if (abort) begin
          state_nxt = IDLE;
          p_c_nxt   = '0;
        end else begin
          state_nxt   = EXEC;
          pm_cont_nxt = rd_data;
        end
      end
      EXEC: begin
        if (abort) begin
          state_nxt = IDLE;
          p_c_nxt   = '0;
        end else begin
          cyc_cnt_nxt = cyc_inc;
          if (halt) begin
            // Branch-to-self: freeze the address/instruction pair the core stopped on.
            state_nxt  = DONE;
            result_nxt = dataout;
          end else begin
            p_c_nxt     = p_c_out;
            pm_cont_nxt = rd_data;
            if (limit) begin
              state_nxt   = DONE;
              timeout_nxt = 1'b1;
              result_nxt  = dataout;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      p_c     <= '0;
      pm_cont <= '0;
      timeout <= 1'b0;
      result  <= '0;
      cyc_cnt <= '0;
    end else begin
      state   <= state_nxt;
      p_c     <= p_c_nxt;
      pm_cont <= pm_cont_nxt;
      timeout <= timeout_nxt;
      result  <= result_nxt;
      cyc_cnt <= cyc_cnt_nxt;
    end
  end

endmodule
